mux_rr_arbiter: RTL
===================

Name: mux_rr_arbiter

Overview:
- Round-robin controller for the 8:1 select mux. It shares the mux between 8 requesters, one owner at a time.
- Drives the mux `select[2:0]` and `enable` directly from registers, plus a one-hot grant back to the requesters.
- Sits between the requester blocks and the mux instance. Grants are fair: the last owner gets the lowest priority at the next arbitration.

Parameters:
- NREQ, 8, number of requesters. Fixed to 8 to match the 3-bit mux select; any other value is illegal.
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold the mux while others wait. Used only with `MUX_ARB_TIMEOUT_EN`. Legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- arb_en  input  1  1 = new grants allowed; 0 = no new grants (current owner is unaffected)
- req  input  8  per-requester request, level; held high for the whole transfer
- grant  output  8  one-hot current owner; all zero when idle
- select  output  3  binary index of the owner, to the mux select
- enable  output  1  mux enable; high exactly when grant is non-zero
- switch_pulse  output  1  one-cycle pulse on every cycle in which grant changes to a new non-zero value

Behaviour:
- Reset: on rst_n=0, asynchronously:
  - grant=0, select=0, enable=0, switch_pulse=0
  - state=IDLE, round-robin pointer ptr=0, hold counter=0
- Reset mid-grant drops ownership immediately, with no handshake.
- Registered design. All outputs are flops. No combinational path from req to any output.
- State machine:
  - IDLE: enable=0, grant=0.
    - If arb_en=1 and req!=0 at edge k: go to OWN. The winner is the first set req bit scanning ptr, ptr+1, ..., ptr+7 (mod 8).
    - At edge k: grant, select and enable are set and switch_pulse=1. Latency is 1 cycle from req being visible to grant.
  - OWN: owner o holds while req[o]=1. select stays stable for the whole ownership.
    - Release: req[o]=0 sampled at edge k.
    - If arb_en=1 and another req bit is set, hand over at the same edge k to the next winner, scanning from o+1 (mod 8). There is no idle bubble; switch_pulse=1.
    - Otherwise go to IDLE at edge k: grant=0, enable=0. select keeps its last value.
- Pointer: on every grant to o, ptr <= o+1 (mod 8, wraps 7 -> 0).
- A requester that drops req and raises it again is treated as a new request. It waits its round-robin turn.
- arb_en=0 during OWN: the owner keeps the mux until it releases, then the block goes to IDLE. Handover is suppressed.
- Requests from non-owners during OWN are not latched. A requester must hold req until granted.
- Hold counter: counts cycles in OWN, cleared on each new grant, saturates at 255.
- switch_pulse is 0 in all other cycles, including the transition to IDLE.
- Invariants:
  - grant is zero or one-hot.
  - enable == |grant.
  - select == index of the grant bit whenever enable=1.

Optional Feature:
- Macro: `MUX_ARB_TIMEOUT_EN`.
- When defined:
  - In OWN, if the hold counter reaches MAX_HOLD and arb_en=1 and any other req bit is set, the owner is forcibly released at that edge. Ownership hands over to the next round-robin winner, exactly as on a normal release.
  - If no other request is pending, the owner keeps the grant and the counter saturates.
  - A preempted requester with req still high waits for its next turn.
- When not defined:
  - No timeout logic is present; ownership ends only on req drop.
  - MAX_HOLD is ignored.

Test Plan:
- Reset, then req=8'h00 for 5 cycles -> grant=0, enable=0, select=0, switch_pulse=0 throughout.
- req=8'h01 at edge 1 -> edge 1: grant=8'h01, select=0, enable=1, switch_pulse=1 for one cycle. Drop req at edge 4 -> edge 4: grant=0, enable=0.
- req=8'h81 held, each owner drops req for one cycle after 2 cycles of ownership -> owners alternate 0, 7, 0, 7 with no idle cycle between handovers (select 0, 7, 0, 7). Verifies the 7 -> 0 wrap of ptr.
- Owner 3 active with req=8'h08, assert rst_n=0 mid-cycle -> grant=0 and enable=0 immediately, with no clock edge. After reset release with req=8'h09 -> requester 0 is granted first (ptr=0).
- With `MUX_ARB_TIMEOUT_EN`, MAX_HOLD=4, req=8'h06 held constantly -> owner 1 for 4 cycles, then owner 2 for 4 cycles, then owner 1, with switch_pulse at each handover. Without the macro -> owner 1 holds indefinitely.
- Owner 5 active, arb_en=0, req=8'h21, owner 5 drops req -> IDLE with grant=0. Set arb_en=1 -> requester 0 is granted 1 cycle later.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner arbiter for the 8:1 select mux: registered one-hot grant, select and enable.
// Optional owner timeout is compiled in with `MUX_ARB_TIMEOUT_EN.
module mux_rr_arbiter #(
  parameter int NREQ     = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            arb_en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [2:0]      select,
  output logic            enable,
  output logic            switch_pulse
);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t          state;
  logic [2:0]      ptr;
  logic [7:0]      hold_cnt;
  logic [7:0]      hold_inc;
  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] pick_onehot;
  logic [2:0]      pick_idx;
  logic            pick_found;
  logic            owner_req;
  logic            at_limit;
  logic            do_grant;

  // First set bit of mask scanning base, base+1, ... (mod 8).
  function automatic logic [3:0] rr_pick(input logic [NREQ-1:0] mask, input logic [2:0] base);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = base + 3'(i);
      if (mask[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    // Owner is excluded so a timeout hands over only to a different requester.
    cand        = req & ~grant;
    {pick_found, pick_idx} = rr_pick(cand, ptr);
    pick_onehot = '0;
    pick_onehot[pick_idx] = 1'b1;
    owner_req   = |(req & grant);
    hold_inc    = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
  end

`ifdef MUX_ARB_TIMEOUT_EN
  assign at_limit = (state == OWN) && (int'(hold_inc) >= MAX_HOLD);
`else
  // MAX_HOLD has no effect without the timeout feature.
  logic [7:0] unused_max_hold;
  assign unused_max_hold = 8'(MAX_HOLD);
  assign at_limit        = 1'b0;
`endif

  assign do_grant = arb_en && pick_found && ((state == IDLE) || !owner_req || at_limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      hold_cnt     <= '0;
      grant        <= '0;
      select       <= '0;
      enable       <= 1'b0;
      switch_pulse <= 1'b0;
    end else begin
      switch_pulse <= 1'b0;
      if (do_grant) begin
        state        <= OWN;
        grant        <= pick_onehot;
        select       <= pick_idx;
        enable       <= 1'b1;
        switch_pulse <= 1'b1;
        ptr          <= pick_idx + 3'd1;
        hold_cnt     <= '0;
      end else if (state == OWN) begin
        if (!owner_req) begin
          // select keeps its last value while idle.
          state    <= IDLE;
          grant    <= '0;
          enable   <= 1'b0;
          hold_cnt <= '0;
        end else begin
          hold_cnt <= hold_inc;
        end
      end
    end
  end

endmodule
